// File: rtl/wrr_arb_pipe.sv
//============================================================================
// Module   : wrr_arb_pipe
// Purpose  : Weighted round-robin N:1 arbiter with grant lock-in and an
//            optional registered output slice.
// Revision : 1.0
//============================================================================
`default_nettype none

module wrr_arb_pipe #(
    parameter int NumIn       = 8,
    parameter int DataWidth   = 32,
    parameter int WeightWidth = 4,
    parameter bit LockIn      = 1'b1,
    parameter bit OutReg      = 1'b1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           flush_i,
    input  logic [NumIn*WeightWidth-1:0]   weight_i,
    input  logic [NumIn-1:0]               req_i,
    output logic [NumIn-1:0]               gnt_o,
    input  logic [NumIn*DataWidth-1:0]     data_i,
    output logic                           req_o,
    input  logic                           gnt_i,
    output logic [DataWidth-1:0]           data_o,
    output logic [$clog2(NumIn)-1:0]       idx_o
);

    localparam int                 c_IDX_W = $clog2(NumIn);
    localparam int                 c_POS_W = c_IDX_W + 1;
    localparam int                 c_CNT_W = WeightWidth + 1;
    localparam logic [c_POS_W-1:0] c_NUM   = c_POS_W'(NumIn);
    localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(NumIn - 1);

    logic [WeightWidth-1:0] wt_arr  [NumIn];
    logic [DataWidth-1:0]   dat_arr [NumIn];

    logic [c_IDX_W-1:0]     ptr_q, ptr_d;
    logic [WeightWidth-1:0] cnt_q, cnt_d;
    logic                   lock_q;
    logic [NumIn-1:0]       req_q;

    logic [NumIn-1:0]       req_eff;
    logic                   any_req;
    logic                   rdy_int;
    logic                   xfer;
    logic [c_IDX_W-1:0]     win;
    logic [c_IDX_W-1:0]     win_nxt;
    logic [c_POS_W-1:0]     pos;
    logic                   found;
    logic [WeightWidth-1:0] base;
    logic [c_CNT_W-1:0]     base_inc;
    logic [c_CNT_W-1:0]     wt_eff;

    for (genvar g = 0; g < NumIn; g++) begin : g_unpack
        assign wt_arr[g]  = weight_i[g*WeightWidth +: WeightWidth];
        assign dat_arr[g] = data_i[g*DataWidth +: DataWidth];
    end

    assign req_eff = lock_q ? req_q : req_i;
    assign any_req = |req_eff;
    assign xfer    = any_req & rdy_int;

    // Cyclic first-one search starting at ptr_q; win defaults to ptr_q when idle.
    always_comb begin
        win   = ptr_q;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < NumIn; k++) begin
            pos = {1'b0, ptr_q} + c_POS_W'(k);
            if (pos >= c_NUM) begin
                pos = pos - c_NUM;
            end
            if (!found && req_eff[pos[c_IDX_W-1:0]]) begin
                found = 1'b1;
                win   = pos[c_IDX_W-1:0];
            end
        end
    end

    always_comb begin
        gnt_o      = '0;
        gnt_o[win] = req_eff[win] & rdy_int;
    end

    assign win_nxt  = (win == c_LAST) ? '0 : win + 1'b1;
    assign wt_eff   = (wt_arr[win] == '0) ? c_CNT_W'(1) : {1'b0, wt_arr[win]};
    assign base     = (win == ptr_q) ? cnt_q : '0;
    assign base_inc = {1'b0, base} + c_CNT_W'(1);

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (xfer) begin
            if (base_inc >= wt_eff) begin
                ptr_d = win_nxt;
                cnt_d = '0;
            end else begin
                ptr_d = win;
                cnt_d = base_inc[WeightWidth-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    if (LockIn) begin : g_lock_on
        always_ff @(posedge clk_i) begin
            if (rst_i || flush_i) begin
                lock_q <= 1'b0;
                req_q  <= '0;
            end else begin
                lock_q <= any_req & ~rdy_int;
                req_q  <= req_eff;
            end
        end
    end else begin : g_lock_off
        assign lock_q = 1'b0;
        assign req_q  = '0;
    end

    if (OutReg) begin : g_out_reg
        logic                 valid_q;
        logic [DataWidth-1:0] data_q;
        logic [c_IDX_W-1:0]   idx_q;

        // A full slice still accepts a new beat in the cycle the old one retires.
        assign rdy_int = ~valid_q | gnt_i;

        always_ff @(posedge clk_i) begin
            if (rst_i || flush_i) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                idx_q   <= '0;
            end else if (xfer) begin
                valid_q <= 1'b1;
                data_q  <= dat_arr[win];
                idx_q   <= win;
            end else if (gnt_i) begin
                valid_q <= 1'b0;
            end
        end

        assign req_o  = valid_q;
        assign data_o = data_q;
        assign idx_o  = idx_q;
    end else begin : g_out_comb
        assign rdy_int = gnt_i;
        assign req_o   = any_req;
        assign data_o  = dat_arr[win];
        assign idx_o   = win;
    end

endmodule

`default_nettype wire

// File: tb/tb_wrr_arb_pipe.sv
//============================================================================
// Module   : tb_wrr_arb_pipe
// Purpose  : Directed and random checks of wrr_arb_pipe (both output modes)
//            against a cycle-level reference model.
// Revision : 1.0
//============================================================================
`default_nettype none

module tb_wrr_arb_pipe;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int WW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, flush;
    logic [N-1:0]    req;
    logic            gnt0, gnt1;
    logic [WW-1:0]   wt  [N];
    logic [DW-1:0]   dat [N];
    logic [N*WW-1:0] weight;
    logic [N*DW-1:0] data;

    logic [N-1:0] gnt_o0, gnt_o1;
    logic         req_o0, req_o1;
    logic [DW-1:0] data_o0, data_o1;
    logic [1:0]   idx_o0, idx_o1;

    always_comb begin
        weight = '0;
        data   = '0;
        for (int i = 0; i < N; i++) begin
            weight[i*WW +: WW] = wt[i];
            data[i*DW +: DW]   = dat[i];
        end
    end

    wrr_arb_pipe #(.NumIn(N), .DataWidth(DW), .WeightWidth(WW), .LockIn(1'b1), .OutReg(1'b0)) u_comb (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .weight_i(weight), .req_i(req),
        .gnt_o(gnt_o0), .data_i(data), .req_o(req_o0), .gnt_i(gnt0),
        .data_o(data_o0), .idx_o(idx_o0));

    wrr_arb_pipe #(.NumIn(N), .DataWidth(DW), .WeightWidth(WW), .LockIn(1'b1), .OutReg(1'b1)) u_reg (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .weight_i(weight), .req_i(req),
        .gnt_o(gnt_o1), .data_i(data), .req_o(req_o1), .gnt_i(gnt1),
        .data_o(data_o1), .idx_o(idx_o1));

    // Reference model state: round-robin pointer, burst count, lock, slice.
    typedef struct {
        int          ptr;
        int          cnt;
        bit          lock;
        logic [3:0]  reqq;
        bit          v;
        logic [15:0] data;
        int          idx;
    } mst_t;

    mst_t m0, m1;
    int   checks = 0;
    int   errors = 0;

    logic [N-1:0]  s_gnt0, s_gnt1;
    logic          s_req_o1;
    logic [DW-1:0] s_data1;
    logic [1:0]    s_idx0, s_idx1;

    int exp44 [10] = '{0, 1, 1, 2, 2, 2, 3, 0, 1, 1};
    int exp45 [6]  = '{0, 1, 1, 2, 3, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic mst_t mzero();
        mst_t z;
        z.ptr = 0; z.cnt = 0; z.lock = 0; z.reqq = '0;
        z.v = 0; z.data = '0; z.idx = 0;
        return z;
    endfunction

    function automatic int winner(input logic [3:0] e, input int ptr);
        for (int k = 0; k < N; k++)
            if (e[(ptr + k) % N]) return (ptr + k) % N;
        return ptr;
    endfunction

    function automatic logic [3:0] eff_of(input mst_t m);
        return m.lock ? m.reqq : req;
    endfunction

    function automatic bit rdy_of(input mst_t m, input bit outreg, input bit g);
        return outreg ? (!m.v || g) : g;
    endfunction

    function automatic mst_t nxt(input mst_t m, input bit outreg, input bit g);
        mst_t       n;
        logic [3:0] e;
        int         w, base, ew;
        bit         r, x;
        n = m;
        e = eff_of(m);
        w = winner(e, m.ptr);
        r = rdy_of(m, outreg, g);
        x = (e != 0) && r;
        if (rst || flush) return mzero();
        if (x) begin
            base = (w == m.ptr) ? m.cnt : 0;
            ew   = (wt[w] == 0) ? 1 : int'(wt[w]);
            if (base + 1 >= ew) begin
                n.ptr = (w + 1) % N;
                n.cnt = 0;
            end else begin
                n.ptr = w;
                n.cnt = base + 1;
            end
        end
        n.lock = (e != 0) && !r;
        n.reqq = e;
        if (outreg) begin
            if (x) begin
                n.v = 1; n.data = dat[w]; n.idx = w;
            end else if (g) begin
                n.v = 0;
            end
        end
        return n;
    endfunction

    task automatic step();
        logic [3:0] e0, e1, g0x, g1x;
        int         w0, w1;
        mst_t       n0, n1;
        @(negedge clk);
        e0  = eff_of(m0);
        w0  = winner(e0, m0.ptr);
        g0x = ((e0 != 0) && gnt0) ? 4'(1 << w0) : 4'd0;
        chk("gnt_o_comb", gnt_o0, g0x);
        chk("req_o_comb", req_o0, (e0 != 0));
        if (e0 != 0) begin
            chk("idx_o_comb", idx_o0, w0);
            chk("data_o_comb", data_o0, dat[w0]);
        end
        e1  = eff_of(m1);
        w1  = winner(e1, m1.ptr);
        g1x = ((e1 != 0) && rdy_of(m1, 1'b1, gnt1)) ? 4'(1 << w1) : 4'd0;
        chk("gnt_o_reg", gnt_o1, g1x);
        chk("req_o_reg", req_o1, m1.v);
        chk("data_o_reg", data_o1, m1.data);
        chk("idx_o_reg", idx_o1, m1.idx);
        if (!rst && m0.lock) chk("lock_hold_comb", req & m0.reqq, m0.reqq);
        if (!rst && m1.lock) chk("lock_hold_reg", req & m1.reqq, m1.reqq);
        s_gnt0 = gnt_o0; s_gnt1 = gnt_o1; s_req_o1 = req_o1;
        s_data1 = data_o1; s_idx0 = idx_o0; s_idx1 = idx_o1;
        n0 = nxt(m0, 1'b0, gnt0);
        n1 = nxt(m1, 1'b1, gnt1);
        @(posedge clk);
        m0 = n0;
        m1 = n1;
        #1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) dat[i] = DW'($urandom);
    endtask

    task automatic set_wt(input int a, input int b, input int c, input int d);
        wt[0] = WW'(a); wt[1] = WW'(b); wt[2] = WW'(c); wt[3] = WW'(d);
    endtask

    task automatic reset_step();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] held;
        logic [3:0]    sticky;
        rst = 1'b1; flush = 1'b0; req = '0; gnt0 = 1'b0; gnt1 = 1'b0;
        set_wt(1, 1, 1, 1);
        rand_data();
        repeat (2) @(posedge clk);
        #1;
        m0 = mzero();
        m1 = mzero();
        rst = 1'b0;

        // Post-reset outputs of the registered slice
        step();
        chk("rst_req_o_reg", s_req_o1, 1'b0);
        chk("rst_data_o_reg", s_data1, '0);
        chk("rst_idx_o_reg", s_idx1, '0);

        // Weighted sequence with weights {1,2,3,1}
        set_wt(1, 2, 3, 1);
        req = 4'b1111; gnt0 = 1'b1; gnt1 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rand_data();
            step();
            chk("seq_w1231", s_idx0, exp44[i]);
        end

        // Zero weight behaves as one
        reset_step();
        set_wt(1, 2, 0, 1);
        for (int i = 0; i < 6; i++) begin
            rand_data();
            step();
            chk("seq_w0", s_idx0, exp45[i]);
        end

        // Lock-in: late request on input 2 is ignored while stalled
        reset_step();
        set_wt(1, 1, 1, 1);
        req = 4'b0010; gnt0 = 1'b1;
        step();
        req = 4'b1010; gnt0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("lock_idx", s_idx0, 2'd3);
            chk("lock_gnt_stall", s_gnt0, 4'b0000);
        end
        req = 4'b1110;
        step();
        chk("lock_idx_late_req", s_idx0, 2'd3);
        gnt0 = 1'b1;
        step();
        chk("lock_release_gnt", s_gnt0, 4'b1000);
        req = 4'b0110;
        step();
        chk("lock_next_idx", s_idx0, 2'd1);

        // Registered slice stall and back-to-back retire/load
        reset_step();
        req = 4'b1111; gnt1 = 1'b0;
        step();
        chk("slice_load_gnt", s_gnt1, 4'b0001);
        rand_data();
        step();
        chk("slice_full_gnt", s_gnt1, 4'b0000);
        held = s_data1;
        rand_data();
        step();
        chk("slice_hold_data", s_data1, held);
        chk("slice_hold_idx", s_idx1, 2'd0);
        gnt1 = 1'b1;
        step();
        chk("slice_retire_gnt", s_gnt1, 4'b0010);
        step();
        chk("slice_reload_idx", s_idx1, 2'd1);
        chk("slice_reload_vld", s_req_o1, 1'b1);

        // Flush mid-burst
        reset_step();
        set_wt(1, 2, 3, 1);
        req = 4'b1111; gnt1 = 1'b1;
        step();
        step();
        flush = 1'b1;
        step();
        chk("flush_cycle_gnt", s_gnt1, 4'b0010);
        flush = 1'b0;
        step();
        chk("flush_req_o", s_req_o1, 1'b0);
        chk("flush_restart_gnt", s_gnt1, 4'b0001);
        step();
        chk("flush_base0_a", s_gnt1, 4'b0010);
        step();
        chk("flush_base0_b", s_gnt1, 4'b0010);

        // Reset during lock
        gnt0 = 1'b0;
        req = 4'b1010;
        step();
        step();
        rst = 1'b1;
        req = 4'b0110;
        step();
        chk("rst_lock_gnt_a", s_gnt0, 4'b0000);
        step();
        chk("rst_lock_gnt_b", s_gnt0, 4'b0000);
        chk("rst_lock_idx", s_idx0, 2'd1);
        rst = 1'b0;

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) wt[$urandom_range(0, N - 1)] = WW'($urandom_range(0, 7));
            rand_data();
            sticky = (m0.lock ? m0.reqq : 4'b0) | (m1.lock ? m1.reqq : 4'b0);
            req   = 4'($urandom) | sticky;
            gnt0  = ($urandom_range(0, 3) != 0);
            gnt1  = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 49) == 0);
            rst   = ($urandom_range(0, 96) == 0);
            step();
        end
        rst = 1'b0;
        flush = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
